// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter that merges N_REQ valid/ready requesters into one channel.
// A grant lasts up to BURST_MAX beats. Accepted beats go to a one-entry output register tagged with the source index.
module hs_rr_arbiter #(
    parameter int DATA_W    = 32,
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int BURST_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*DATA_W-1:0] s_data,
    input  logic [N_REQ-1:0]        s_valid,
    output logic [N_REQ-1:0]        s_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic [IDX_W-1:0]        m_id,
    output logic                    m_valid,
    input  logic                    m_ready
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [IDX_W-1:0]  m_id_q, m_id_d;
    logic              m_valid_q, m_valid_d;

    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              out_free;
    logic              xfer;
    logic              found;
    logic [IDX_W-1:0]  pick;
    int                scan_idx;

    // Only the granted requester is ever looked at.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q == IDX_W'(i)) begin
                sel_valid = s_valid[i];
                sel_data  = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scan starts at rr_ptr and wraps modulo N_REQ. The first valid requester wins.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && scan_idx == j && s_valid[j]) begin
                    found = 1'b1;
                    pick  = IDX_W'(j);
                end
            end
        end
    end

    // s_ready depends on m_ready only, never on s_valid.
    assign out_free = !m_valid_q || m_ready;
    assign xfer     = (state_q == GRANT) && out_free && sel_valid;

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_ready[i] = (state_q == GRANT) && out_free && (gnt_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        m_data_d   = m_data_q;
        m_id_d     = m_id_q;
        m_valid_d  = m_valid_q;

        if (m_valid_q && m_ready) m_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    m_data_d   = sel_data;
                    m_id_d     = gnt_q;
                    m_valid_d  = 1'b1;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                // Release after the last beat of a burst, or when the owner goes idle without a transfer.
                if ((xfer && beat_cnt_q == CNT_W'(BURST_MAX - 1)) || !sel_valid) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            m_data_q   <= '0;
            m_id_q     <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            m_data_q   <= m_data_d;
            m_id_q     <= m_id_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_id    = m_id_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter. The main instance uses BURST_MAX=8 with four counting sources.
// A second two-requester instance uses BURST_MAX=1.
module tb_hs_rr_arbiter;
    logic         clk;
    logic         rst_n;
    logic [127:0] s_data;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [31:0]  m_data;
    logic [1:0]   m_id;
    logic         m_valid;
    logic         m_ready;

    logic [63:0]  s_data1;
    logic [1:0]   s_valid1;
    logic [1:0]   s_ready1;
    logic [31:0]  m_data1;
    logic [0:0]   m_id1;
    logic         m_valid1;
    logic         m_ready1;

    int tests = 0;
    int fails = 0;
    int nxt [4] = '{1, 1, 1, 1};
    logic [15:0] src_cnt [4] = '{16'd1, 16'd1, 16'd1, 16'd1};

    hs_rr_arbiter #(.DATA_W(32), .N_REQ(4), .IDX_W(2), .BURST_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_id(m_id), .m_valid(m_valid), .m_ready(m_ready)
    );

    hs_rr_arbiter #(.DATA_W(32), .N_REQ(2), .IDX_W(1), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .m_data(m_data1), .m_id(m_id1), .m_valid(m_valid1), .m_ready(m_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counting sources: a requester's count advances only on its own handshake.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (s_valid[i] && s_ready[i]) src_cnt[i] <= src_cnt[i] + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) s_data[i*32 +: 32] = {16'(i), src_cnt[i]};
    end

    function automatic logic [31:0] beat(int i, int n);
        return {16'(i), 16'(n)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_mv, input logic [1:0] exp_id,
                           input logic [31:0] exp_d, input logic [3:0] exp_sr, input logic with_data);
        chk({tag, "_mvalid"}, 64'(m_valid), 64'(exp_mv));
        chk({tag, "_sready"}, 64'(s_ready), 64'(exp_sr));
        if (with_data) begin
            chk({tag, "_mid"}, 64'(m_id), 64'(exp_id));
            chk({tag, "_mdata"}, 64'(m_data), 64'(exp_d));
        end
    endtask

    task automatic chk_beat(input string tag, input int g, input logic [3:0] exp_sr);
        logic [31:0] d;
        d = beat(g, nxt[g]);
        nxt[g]++;
        chk_out(tag, 1'b1, 2'(g), d, exp_sr, 1'b1);
    endtask

    initial begin
        logic [31:0] held;
        rst_n    = 1'b0;
        s_valid  = 4'b0000;
        m_ready  = 1'b1;
        s_data1  = {32'hB0B0_0001, 32'hA0A0_0000};
        s_valid1 = 2'b00;
        m_ready1 = 1'b1;

        // Reset values
        repeat (2) step();
        chk_out("reset", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b1);
        chk("reset_mvalid1", 64'(m_valid1), 64'd0);
        rst_n = 1'b1;
        step();
        chk_out("idle", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b0);

        // Requester 1 streams: beats 1..8, one bubble, beats 9..16
        s_valid = 4'b0010;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 1 || k == 10) chk_out($sformatf("s1_k%0d", k), 1'b0, 2'd0, 32'd0, 4'b0010, 1'b0);
            else chk_beat($sformatf("s1_k%0d", k), 1, (k == 9 || k == 18) ? 4'b0000 : 4'b0010);
        end
        s_valid = 4'b0000;
        step();
        chk_out("s1_drain", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b0);

        // Requester 2 with a 5-cycle downstream stall mid-burst (rr_ptr is 2)
        s_valid = 4'b0100;
        step();
        chk_out("s2_grant", 1'b0, 2'd0, 32'd0, 4'b0100, 1'b0);
        step();
        chk_beat("s2_b1", 2, 4'b0100);
        step();
        chk_beat("s2_b2", 2, 4'b0100);
        held = beat(2, 2);
        m_ready = 1'b0;
        #1;
        chk_out("s2_stall0", 1'b1, 2'd2, held, 4'b0000, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_out($sformatf("s2_stall%0d", k), 1'b1, 2'd2, held, 4'b0000, 1'b1);
        end
        m_ready = 1'b1;
        #1;
        chk_out("s2_resume", 1'b1, 2'd2, held, 4'b0100, 1'b1);
        for (int k = 3; k <= 8; k++) begin
            step();
            chk_beat($sformatf("s2_b%0d", k), 2, (k == 8) ? 4'b0000 : 4'b0100);
        end
        s_valid = 4'b0000;
        step();
        chk_out("s2_drain", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b0);

        // Requester 3 mid-burst, then a one-cycle reset pulse (rr_ptr is 3)
        s_valid = 4'b1000;
        step();
        chk_out("s3_grant", 1'b0, 2'd0, 32'd0, 4'b1000, 1'b0);
        step();
        chk_beat("s3_b1", 3, 4'b1000);
        step();
        chk_beat("s3_b2", 3, 4'b1000);
        s_valid = 4'b1001;
        #1;
        chk_out("s3_other_valid", 1'b1, 2'd3, beat(3, 2), 4'b1000, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("s3_rst_async", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b1);
        step();
        chk_out("s3_rst_held", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b1);
        rst_n = 1'b1;
        step();
        chk_out("s3_regrant0", 1'b0, 2'd0, 32'd0, 4'b0001, 1'b0);

        // Requester 0 goes idle after 2 beats while requester 3 waits, then rr_ptr wraps
        step();
        chk_beat("s4_b1", 0, 4'b0001);
        step();
        chk_beat("s4_b2", 0, 4'b0001);
        s_valid = 4'b1000;
        #1;
        chk_out("s4_no_valid_path", 1'b1, 2'd0, beat(0, 2), 4'b0001, 1'b1);
        step();
        chk_out("s4_release", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b0);
        step();
        chk_out("s4_grant3", 1'b0, 2'd0, 32'd0, 4'b1000, 1'b0);
        step();
        chk_beat("s4_r3_b1", 3, 4'b1000);
        step();
        chk_beat("s4_r3_b2", 3, 4'b1000);
        s_valid = 4'b0011;
        step();
        chk_out("s4_release3", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b0);
        step();
        chk_out("s4_wrap_grant0", 1'b0, 2'd0, 32'd0, 4'b0001, 1'b0);
        step();
        chk_beat("s4_r0_b3", 0, 4'b0001);
        s_valid = 4'b0000;
        step();
        chk_out("s4_drain", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b0);

        // All four valid from a fresh reset: grant order 0,1,2,3,0 with 8-beat bursts
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        s_valid = 4'b1111;
        for (int k = 1; k <= 45; k++) begin
            int p;
            int g;
            step();
            p = (k - 1) % 9;
            g = ((k - 1) / 9) % 4;
            if (p == 0) chk_out($sformatf("s5_k%0d", k), 1'b0, 2'd0, 32'd0, 4'(1) << g, 1'b0);
            else chk_beat($sformatf("s5_k%0d", k), g, (p == 8) ? 4'b0000 : 4'(1) << g);
        end
        s_valid = 4'b0000;
        step();
        chk_out("s5_drain", 1'b0, 2'd0, 32'd0, 4'b0000, 1'b0);

        // BURST_MAX=1: strict alternation 0,1,0,1 with an idle cycle between grants
        s_valid1 = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            int p;
            int g;
            step();
            p = (k - 1) % 2;
            g = ((k - 1) / 2) % 2;
            if (p == 0) begin
                chk($sformatf("s6_k%0d_mvalid", k), 64'(m_valid1), 64'd0);
                chk($sformatf("s6_k%0d_sready", k), 64'(s_ready1), 64'(2'(1) << g));
            end else begin
                chk($sformatf("s6_k%0d_mvalid", k), 64'(m_valid1), 64'd1);
                chk($sformatf("s6_k%0d_sready", k), 64'(s_ready1), 64'd0);
                chk($sformatf("s6_k%0d_mid", k), 64'(m_id1), 64'(g));
                chk($sformatf("s6_k%0d_mdata", k), 64'(m_data1),
                    64'((g == 0) ? 32'hA0A0_0000 : 32'hB0B0_0001));
            end
        end
        s_valid1 = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
